// File: rtl/shared_fifo_arbiter_pkg.sv
// Shared sizing helpers and buffer-entry layout for the shared FIFO arbiter.
// Each buffer entry is stored as {index, payload}.
package shared_fifo_arbiter_pkg;

    // Payload occupies the low bits of an entry; the source index sits directly above it.
    localparam int unsigned ENTRY_PAYLOAD_LSB = 0;

    function automatic int unsigned index_width(input int unsigned num_inputs);
        return (num_inputs > 1) ? $clog2(num_inputs) : 1;
    endfunction

    function automatic int unsigned occ_width(input int unsigned num_slots);
        return $clog2(num_slots + 1);
    endfunction

    function automatic int unsigned entry_width(input int unsigned iw, input int unsigned dw);
        return iw + dw;
    endfunction

    function automatic int unsigned entry_index_lsb(input int unsigned dw);
        return ENTRY_PAYLOAD_LSB + dw;
    endfunction

    // (base + off) mod n, valid for base < n and off <= n.
    function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                             input int unsigned n);
        int unsigned sum;
        sum = base + off;
        return (sum >= n) ? sum - n : sum;
    endfunction

endpackage

// File: rtl/shared_fifo_arbiter_if.sv
// Producer/consumer signal bundle of the shared FIFO arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface shared_fifo_arbiter_if
    import shared_fifo_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int NUM_SLOTS  = 4,
    parameter int DATA_TYPE  = 32
);
    localparam int IW = int'(index_width(NUM_INPUTS));
    localparam int CW = int'(occ_width(NUM_SLOTS));

    logic [NUM_INPUTS*DATA_TYPE-1:0] ins;
    logic [NUM_INPUTS-1:0]           ins_valid;
    logic [NUM_INPUTS-1:0]           ins_ready;
    logic [DATA_TYPE-1:0]            outs;
    logic [IW-1:0]                   outs_index;
    logic                            outs_valid;
    logic                            outs_ready;
    logic [CW-1:0]                   occupancy;

    modport master (
        output ins,
        output ins_valid,
        input  ins_ready,
        input  outs,
        input  outs_index,
        input  outs_valid,
        output outs_ready,
        input  occupancy
    );

    modport slave (
        input  ins,
        input  ins_valid,
        output ins_ready,
        output outs,
        output outs_index,
        output outs_valid,
        input  outs_ready,
        output occupancy
    );

endinterface

// File: rtl/shared_fifo_arbiter_elastic_fifo_inner.sv
// Circular buffer storage with head/tail pointers; fullness is tracked by the caller.
// Read data is the registered head slot, so a write is never visible in the same cycle.
module elastic_fifo_inner #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    // Power-of-two depth: pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en_i) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; validity is carried by the pointers and occupancy.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/shared_fifo_arbiter.sv
// Round-robin arbiter feeding NUM_INPUTS producer channels into one shared FIFO.
// Each entry records its source channel so the consumer sees {outs_index, outs}.
module shared_fifo_arbiter
    import shared_fifo_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int NUM_SLOTS  = 4,
    parameter int DATA_TYPE  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    shared_fifo_arbiter_if.slave  bus
);
    localparam int IW = int'(index_width(NUM_INPUTS));
    localparam int CW = int'(occ_width(NUM_SLOTS));
    localparam int EW = int'(entry_width(IW, DATA_TYPE));
    localparam int IDX_LSB = int'(entry_index_lsb(DATA_TYPE));

    logic [IW-1:0] prio_q, prio_d;
    logic [CW-1:0] occ_q, occ_d;

    logic          grant_found;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] cand;
    logic          full;
    logic          accept;
    logic          wr_en;
    logic          rd_en;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = IW'(wrap_add(32'(prio_q), k, NUM_INPUTS));
            if (!grant_found && bus.ins_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A full buffer can still take a write when the head leaves in the same cycle.
    assign full   = (occ_q == CW'(NUM_SLOTS));
    assign accept = !full || bus.outs_ready;
    assign wr_en  = !rst && grant_found && accept;
    assign rd_en  = !rst && bus.outs_valid && bus.outs_ready;

    always_comb begin
        bus.ins_ready = '0;
        if (wr_en) bus.ins_ready[grant_idx] = 1'b1;
    end

    assign wr_entry = {grant_idx, bus.ins[grant_idx*DATA_TYPE +: DATA_TYPE]};

    always_comb begin
        prio_d = prio_q;
        occ_d  = occ_q;
        if (wr_en) prio_d = IW'(wrap_add(32'(grant_idx), 1, NUM_INPUTS));
        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= '0;
            occ_q  <= '0;
        end else begin
            prio_q <= prio_d;
            occ_q  <= occ_d;
        end
    end

    elastic_fifo_inner #(
        .WIDTH (EW),
        .DEPTH (NUM_SLOTS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_entry),
        .rd_en_i   (rd_en),
        .rd_data_o (rd_entry)
    );

    assign bus.outs       = rd_entry[ENTRY_PAYLOAD_LSB +: DATA_TYPE];
    assign bus.outs_index = rd_entry[IDX_LSB +: IW];
    assign bus.outs_valid = (occ_q != '0);
    assign bus.occupancy  = occ_q;

endmodule

// File: tb/tb_shared_fifo_arbiter.sv
// Directed and random stimulus for shared_fifo_arbiter (4 inputs, 4 slots, 8-bit payload),
// checked against a reference model with a queue of expected {index, payload} entries.
module tb_shared_fifo_arbiter;
    localparam int NI = 4;
    localparam int NS = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shared_fifo_arbiter_if #(.NUM_INPUTS(NI), .NUM_SLOTS(NS), .DATA_TYPE(DW)) bus ();

    shared_fifo_arbiter #(.NUM_INPUTS(NI), .NUM_SLOTS(NS), .DATA_TYPE(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef logic [9:0] entry_t;
    entry_t    sb[$];
    int        m_prio  = 0;
    bit        m_known = 1'b0;
    logic [3:0] exp_ready;
    bit        exp_wr;
    int        exp_g;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit found;
        found = 1'b0;
        exp_g = 0;
        for (int k = 0; k < NI; k++) begin
            int c;
            c = (m_prio + k) % NI;
            if (!found && bus.ins_valid[c]) begin
                found = 1'b1;
                exp_g = c;
            end
        end
        exp_wr    = !rst && found && ((sb.size() < NS) || bus.outs_ready);
        exp_ready = exp_wr ? 4'(1 << exp_g) : 4'b0000;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        model_eval();
        check("ins_ready", bus.ins_ready, exp_ready);
        if (m_known) begin
            check("occupancy", bus.occupancy, sb.size());
            check("outs_valid", bus.outs_valid, sb.size() != 0);
            if (sb.size() != 0) begin
                check("outs", bus.outs, sb[0][7:0]);
                check("outs_index", bus.outs_index, sb[0][9:8]);
            end
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_prio  = 0;
            m_known = 1'b1;
        end else begin
            if (sb.size() != 0 && bus.outs_ready) void'(sb.pop_front());
            if (exp_wr) begin
                sb.push_back({2'(exp_g), bus.ins[exp_g*DW +: DW]});
                m_prio = (exp_g + 1) % NI;
            end
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] onehot [5];
        onehot[0] = 4'b0001; onehot[1] = 4'b0010; onehot[2] = 4'b0100;
        onehot[3] = 4'b1000; onehot[4] = 4'b0001;

        rst            = 1'b1;
        bus.ins        = '0;
        bus.ins_valid  = '0;
        bus.outs_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Round-robin over all four channels with a free-running consumer.
        bus.ins        = 32'h44332211;
        bus.ins_valid  = 4'hF;
        bus.outs_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr_grant", bus.ins_ready, onehot[i]);
            tick();
        end
        bus.ins_valid = 4'h0;
        tick();
        tick();

        // Single producer, blocked consumer: buffer fills then back-pressures.
        bus.ins_valid  = 4'b0100;
        bus.outs_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.ins[23:16] = 8'(8'hA0 + i);
            #1;
            check("fill_ready", bus.ins_ready, (i < 4) ? 4'b0100 : 4'b0000);
            tick();
        end
        check("fill_occ", bus.occupancy, 4);

        // Full buffer with simultaneous write and read across pointer wrap.
        bus.ins_valid  = 4'b0010;
        bus.outs_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.ins[15:8] = 8'(8'hB0 + i);
            #1;
            check("full_rw_ready", bus.ins_ready, 4'b0010);
            tick();
            check("full_rw_occ", bus.occupancy, 4);
        end
        bus.ins_valid = 4'b0000;
        for (int i = 0; i < 4; i++) tick();

        // Move prio to 3, then contend between channels 0 and 3.
        bus.ins_valid = 4'b0100;
        tick();
        bus.ins_valid = 4'b0000;
        tick();
        bus.ins       = 32'hD3C2B1A0;
        bus.ins_valid = 4'b1001;
        #1;
        check("prio3_first", bus.ins_ready, 4'b1000);
        tick();
        #1;
        check("prio3_second", bus.ins_ready, 4'b0001);
        tick();
        bus.ins_valid = 4'b1111;
        #1;
        check("prio1_grant", bus.ins_ready, 4'b0010);
        tick();
        bus.ins_valid = 4'b0000;
        for (int i = 0; i < 4; i++) tick();

        // Random traffic with varying back-pressure.
        for (int i = 0; i < 60; i++) begin
            bus.ins        = $urandom;
            bus.ins_valid  = 4'($urandom_range(0, 15));
            bus.outs_ready = ($urandom_range(0, 1) == 1);
            tick();
        end

        // Reset with three entries buffered.
        bus.ins_valid  = 4'b0000;
        bus.outs_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.ins_valid  = 4'b0001;
        bus.outs_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("pre_rst_occ", bus.occupancy, 3);
        bus.ins_valid = 4'hF;
        rst           = 1'b1;
        #1;
        check("rst_ready", bus.ins_ready, 4'b0000);
        tick();
        rst = 1'b0;
        check("post_rst_occ", bus.occupancy, 0);
        check("post_rst_valid", bus.outs_valid, 1'b0);
        bus.ins_valid  = 4'b1010;
        bus.outs_ready = 1'b1;
        #1;
        check("post_rst_grant", bus.ins_ready, 4'b0010);
        tick();
        bus.ins_valid = 4'b0000;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shared_fifo_arbiter.md
SHARED_FIFO_ARBITER -- requirements
Module: shared_fifo_arbiter

Interface
REQ-001 Parameter NUM_INPUTS, default 4: number of requesting producer channels (>=2).
REQ-002 Parameter NUM_SLOTS, default 4: depth of the shared buffer (>=2, power of two).
REQ-003 Parameter DATA_TYPE, default 32: payload width in bits.
REQ-004 Derived IW = max(1, clog2(NUM_INPUTS)); CW = clog2(NUM_SLOTS+1).
REQ-005 One clock; reset is synchronous and active-high; clock port clk, reset port rst.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 ins  in  NUM_INPUTS*DATA_TYPE  packed payloads; channel i occupies bits [i*DATA_TYPE +: DATA_TYPE].
REQ-009 ins_valid  in  NUM_INPUTS  per-channel valid.
REQ-010 ins_ready  out  NUM_INPUTS  per-channel ready.
REQ-011 outs  out  DATA_TYPE  head-of-buffer payload.
REQ-012 outs_index  out  IW  source channel of outs.
REQ-013 outs_valid  out  1  buffer non-empty.
REQ-014 outs_ready  in  1  consumer accepts.
REQ-015 occupancy  out  CW  entries currently stored.

Function
REQ-016 Register prio (IW bits) SHALL hold the highest-priority channel index.
REQ-017 Grant SHALL go to the first channel with ins_valid=1, searching prio, prio+1, ... cyclically modulo NUM_INPUTS; at most one grant per cycle.
REQ-018 ins_ready[i] SHALL be 1 only if i is granted and the buffer accepts (not full, or full with outs_ready=1); all other ins_ready bits 0.
REQ-019 Transfer on channel i SHALL occur when ins_valid[i] & ins_ready[i]; the buffer SHALL store {i, payload} in that cycle.
REQ-020 On a transfer from channel g, prio SHALL become (g+1) mod NUM_INPUTS next cycle; otherwise prio holds.
REQ-021 A granted channel whose ins_valid drops before transfer SHALL lose the grant with no state change.
REQ-022 The buffer SHALL be FIFO-ordered; an entry written in cycle t SHALL appear on outs/outs_index no earlier than cycle t+1 (no combinational bypass).
REQ-023 outs_valid SHALL equal (occupancy != 0); a read occurs on outs_valid & outs_ready.
REQ-024 occupancy SHALL be +1 on write only, -1 on read only, unchanged on simultaneous write+read or neither.
REQ-025 Full (occupancy == NUM_SLOTS) with outs_ready=1: write and read SHALL both occur; occupancy stays NUM_SLOTS.
REQ-026 Full with outs_ready=0: all ins_ready SHALL be 0.
REQ-027 Empty: write alone SHALL set occupancy to 1; outs_valid rises next cycle.
REQ-028 Head/tail pointers SHALL wrap modulo NUM_SLOTS with no slot lost or duplicated.
REQ-029 ins_ready MAY depend combinationally on ins_valid and outs_ready; outs, outs_index, outs_valid, occupancy SHALL be registered-state only.

Reset
REQ-030 On rst=1 at a rising edge: prio=0, occupancy=0, pointers=0, outs_valid=0; stored entries discarded.
REQ-031 During rst=1 cycles all ins_ready SHALL be 0 and no transfer SHALL be recorded.
REQ-032 Reset mid-operation SHALL drop all buffered entries; first post-reset grant follows prio=0.
REQ-033 Payload storage contents need not be reset; outs is don't-care while outs_valid=0.

Structure
REQ-034 A shared package SHALL hold the index-width and occupancy-width helper functions and the {index, payload} entry layout constant.
REQ-035 The buffer SHALL be one sub-module, elastic_fifo_inner, instantiated with DATA_TYPE+IW width and NUM_SLOTS depth; arbitration, prio and occupancy live in the top.

Verification (NUM_INPUTS=4, NUM_SLOTS=4, DATA_TYPE=8)
REQ-036 All four valid, ins = {0x44,0x33,0x22,0x11}, outs_ready=1 -> transfers from channels 0,1,2,3,0 on consecutive cycles; outs 0x11,0x22,0x33,0x44 with outs_index 0,1,2,3 one cycle later each.
REQ-037 Only channel 2 valid, outs_ready=0 for 6 cycles -> 4 transfers, occupancy reaches 4, ins_ready[2]=0 from cycle 5.
REQ-038 Full, channel 1 valid, outs_ready=1 -> same-cycle write and read; occupancy stays 4; order preserved across pointer wrap.
REQ-039 prio=3, channels 0 and 3 valid -> channel 3 granted first, then channel 0, prio=1 after.
REQ-040 rst asserted with occupancy=3 -> next cycle occupancy=0, outs_valid=0; first grant after reset goes to lowest valid index.
